// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: PC mux selects, fetch FSM encodings,
// the IF/ID slot entry layout and small address helpers.
package instr_fetch_pkg;

    // RV32 canonical NOP (addi x0, x0, 0), used as filler on a PC fault.
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Branch MUX select in front of program_counter.
    typedef enum logic [1:0] {
        PC_MUX_PC_ADDER = 2'd0,
        PC_MUX_ALU_OUT  = 2'd1
    } pc_mux_enum_t;

    // Fetch FSM encodings.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // Data written into the IF/ID slot on a load.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        misaligned;
    } slot_entry_t;

    // Sequential word address; wraps modulo 2^32.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + INSTR_BYTES;
    endfunction

    // True when the address lies on a 32-bit word boundary.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_if_id_slot.sv
// One-entry IF/ID pipeline register. Priority: flush > load > consume.
// A load in the same cycle as a consume replaces the old entry, so the
// slot can stream one instruction per cycle when the decoder keeps up.
module if_id_slot
    import instr_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  slot_entry_t load_entry,
    input  logic        consume,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);

    // Slot register: reset to an empty NOP entry, then flush/load/consume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            instr      <= NOP_INSTR;
            pc         <= 32'd0;
            pc_plus4   <= 32'd0;
            misaligned <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid      <= 1'b1;
            instr      <= load_entry.instr;
            pc         <= load_entry.pc;
            pc_plus4   <= next_word_addr(load_entry.pc);
            misaligned <= load_entry.misaligned;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage sitting after program_counter. Issues one word
// request per PC, waits for a variable-latency response, fills the IF/ID
// slot and tells program_counter when to advance.
//
// Handshake semantics (request channel and IF/ID slot alike): a transfer
// happens on a rising edge where valid & ready are both high. Once valid
// is raised it stays high with stable payload until the transfer, except
// that a flush withdraws a pending request. ready may depend on valid.
// The response channel has no back-pressure: resp_valid is a one-cycle
// strobe that must be taken when it arrives (or dropped if wrong-path).
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  pc,
    input  logic         flush,
    output logic         pc_en,
    output logic         imem_req_valid,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_req_ready,
    input  logic         imem_resp_valid,
    input  logic [31:0]  imem_resp_data,
    output logic         id_valid,
    input  logic         id_ready,
    output logic [31:0]  id_instr,
    output logic [31:0]  id_pc,
    output logic [31:0]  id_pc_plus4,
    output logic         id_misaligned,
    output fetch_state_t fsm_state
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  req_pc;
    logic         slot_free;
    logic         pc_aligned;
    logic         req_fire;
    logic         slot_load;
    slot_entry_t  slot_entry;

    // A request may only go out when its response is guaranteed a home.
    assign slot_free     = !id_valid || id_ready;
    assign pc_aligned    = is_word_aligned(pc);
    assign imem_req_addr = pc;
    assign fsm_state     = state;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Remember the PC of the outstanding request; pc moves on after pc_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_pc <= 32'd0;
        end else if (req_fire) begin
            req_pc <= pc;
        end
    end

    // Next state, request issue, slot load and PC enable.
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        req_fire       = 1'b0;
        pc_en          = 1'b0;
        slot_load      = 1'b0;
        slot_entry     = '{instr: imem_resp_data, pc: req_pc, misaligned: 1'b0};

        case (state)
            IDLE: begin
                imem_req_valid = slot_free && !flush && pc_aligned;
                req_fire       = imem_req_valid && imem_req_ready;
                if (req_fire) begin
                    pc_en      = 1'b1;
                    state_next = WAIT;
                end else if (!pc_aligned && slot_free && !flush) begin
                    // Park a fault marker in the slot instead of fetching.
                    slot_load  = 1'b1;
                    slot_entry = '{instr: NOP_INSTR, pc: pc, misaligned: 1'b1};
                    state_next = FAULT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    slot_load  = 1'b1;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                // Wrong-path response: swallow it and resume.
                if (imem_resp_valid) begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A redirect overrides everything: no request, PC reloads, and any
        // response still in flight belongs to the old path.
        if (flush) begin
            pc_en          = 1'b1;
            imem_req_valid = 1'b0;
            req_fire       = 1'b0;
            slot_load      = 1'b0;
            case (state)
                WAIT, DRAIN: state_next = imem_resp_valid ? IDLE : DRAIN;
                default:     state_next = IDLE;
            endcase
        end

        if (!rst_n) begin
            imem_req_valid = 1'b0;
            req_fire       = 1'b0;
            pc_en          = 1'b0;
        end
    end

    if_id_slot u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .load       (slot_load),
        .load_entry (slot_entry),
        .consume    (id_ready),
        .valid      (id_valid),
        .instr      (id_instr),
        .pc         (id_pc),
        .pc_plus4   (id_pc_plus4),
        .misaligned (id_misaligned)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized run
// against a transaction-level model of the PC, memory and decoder.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  pc;
    logic         flush;
    logic         pc_en;
    logic         imem_req_valid;
    logic [31:0]  imem_req_addr;
    logic         imem_req_ready;
    logic         imem_resp_valid;
    logic [31:0]  imem_resp_data;
    logic         id_valid;
    logic         id_ready;
    logic [31:0]  id_instr;
    logic [31:0]  id_pc;
    logic [31:0]  id_pc_plus4;
    logic         id_misaligned;
    fetch_state_t fsm_state;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc              (pc),
        .flush           (flush),
        .pc_en           (pc_en),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .id_misaligned   (id_misaligned),
        .fsm_state       (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive point: just after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sample point: the falling edge, with inputs settled.
    task automatic sample();
        @(negedge clk);
    endtask

    // Memory contents seen by the randomized run.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Randomized-run model state.
    logic [31:0] model_pc;
    logic [31:0] pend_addr;
    logic [31:0] e;
    logic        pend;
    logic        drop;
    logic        resp_live;
    logic        hs;
    int          rem;
    int          delivered;

    initial begin
        rst_n = 1'b0; pc = 32'd0; flush = 1'b0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'd0; id_ready = 1'b0;

        // ---- reset values ----
        imem_req_ready = 1'b1;
        sample();
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check1("rst_pc_en", pc_en, 1'b0);
        next_cycle();
        sample();
        check1("rst_id_valid", id_valid, 1'b0);
        check1("rst_misaligned", id_misaligned, 1'b0);
        check32("rst_instr", id_instr, NOP_INSTR);
        check32("rst_id_pc", id_pc, 32'd0);
        check32("rst_pc_plus4", id_pc_plus4, 32'd0);
        check32("rst_state", 32'(fsm_state), 32'(IDLE));

        // ---- first fetch, latency 1 ----
        next_cycle(); rst_n = 1'b1; pc = 32'd0; imem_req_ready = 1'b1; id_ready = 1'b0;
        sample();
        check1("f1_req_valid", imem_req_valid, 1'b1);
        check32("f1_req_addr", imem_req_addr, 32'd0);
        check1("f1_pc_en", pc_en, 1'b1);
        next_cycle(); pc = 32'd4; imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
        sample();
        check1("f1_pc_en_pulse", pc_en, 1'b0);
        check32("f1_state_wait", 32'(fsm_state), 32'(WAIT));
        next_cycle(); imem_resp_valid = 1'b0;
        sample();
        check1("f1_id_valid", id_valid, 1'b1);
        check32("f1_instr", id_instr, 32'h0050_0093);
        check32("f1_id_pc", id_pc, 32'd0);
        check32("f1_pc_plus4", id_pc_plus4, 32'd4);

        // ---- slot full blocks the next request ----
        check1("full_req_valid", imem_req_valid, 1'b0);
        check1("full_pc_en", pc_en, 1'b0);
        next_cycle();
        sample();
        check1("full_pc_en2", pc_en, 1'b0);
        next_cycle(); id_ready = 1'b1;
        sample();
        check1("unblock_req_valid", imem_req_valid, 1'b1);
        check1("unblock_pc_en", pc_en, 1'b1);
        check32("unblock_addr", imem_req_addr, 32'd4);
        next_cycle(); id_ready = 1'b0; pc = 32'd8;
        sample();
        check1("unblock_consumed", id_valid, 1'b0);
        check1("unblock_wait_pc_en", pc_en, 1'b0);
        next_cycle(); imem_resp_valid = 1'b1; imem_resp_data = 32'hABCD_0001;
        sample();
        next_cycle(); imem_resp_valid = 1'b0;
        sample();
        check1("f2_id_valid", id_valid, 1'b1);
        check32("f2_instr", id_instr, 32'hABCD_0001);
        check32("f2_id_pc", id_pc, 32'd4);
        check32("f2_pc_plus4", id_pc_plus4, 32'd8);

        // ---- req_ready low for 3 cycles ----
        next_cycle(); flush = 1'b1;
        sample();
        check1("fl_pc_en", pc_en, 1'b1);
        check1("fl_req_valid", imem_req_valid, 1'b0);
        next_cycle(); flush = 1'b0; pc = 32'h10; imem_req_ready = 1'b0;
        sample();
        check1("fl_cleared_slot", id_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) begin
                next_cycle();
                sample();
            end
            check1("stall_req_valid", imem_req_valid, 1'b1);
            check32("stall_addr", imem_req_addr, 32'h10);
            check1("stall_pc_en", pc_en, 1'b0);
        end
        next_cycle(); imem_req_ready = 1'b1;
        sample();
        check1("stall_ready_pc_en", pc_en, 1'b1);
        check32("stall_ready_addr", imem_req_addr, 32'h10);

        // ---- flush one cycle after handshake, latency 3 ----
        next_cycle(); pc = 32'h14; flush = 1'b1;
        sample();
        check1("drain_flush_pc_en", pc_en, 1'b1);
        next_cycle(); flush = 1'b0; pc = 32'h40;
        sample();
        check32("drain_state", 32'(fsm_state), 32'(DRAIN));
        check1("drain_no_req", imem_req_valid, 1'b0);
        check1("drain_pc_en", pc_en, 1'b0);
        next_cycle(); imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        sample();
        check1("drain_no_req2", imem_req_valid, 1'b0);
        next_cycle(); imem_resp_valid = 1'b0;
        sample();
        check1("drain_dropped", id_valid, 1'b0);
        check32("drain_to_idle", 32'(fsm_state), 32'(IDLE));
        check32("redirect_addr", imem_req_addr, 32'h40);
        check1("redirect_pc_en", pc_en, 1'b1);
        next_cycle(); pc = 32'h44; imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_2222;
        sample();
        next_cycle(); imem_resp_valid = 1'b0;
        sample();
        check1("redirect_id_valid", id_valid, 1'b1);
        check32("redirect_id_pc", id_pc, 32'h40);
        check32("redirect_instr", id_instr, 32'h1111_2222);

        // ---- misaligned PC fault ----
        next_cycle(); flush = 1'b1;
        sample();
        next_cycle(); flush = 1'b0; pc = 32'h102;
        sample();
        check1("mis_no_req", imem_req_valid, 1'b0);
        check1("mis_pc_en", pc_en, 1'b0);
        next_cycle();
        sample();
        check1("mis_id_valid", id_valid, 1'b1);
        check1("mis_flag", id_misaligned, 1'b1);
        check32("mis_instr", id_instr, NOP_INSTR);
        check32("mis_id_pc", id_pc, 32'h102);
        check32("mis_pc_plus4", id_pc_plus4, 32'h106);
        check32("mis_state", 32'(fsm_state), 32'(FAULT));
        check1("mis_hold_pc_en", pc_en, 1'b0);
        next_cycle(); id_ready = 1'b1;
        sample();
        check1("mis_hold_req", imem_req_valid, 1'b0);
        next_cycle(); id_ready = 1'b0;
        sample();
        check1("mis_consumed", id_valid, 1'b0);
        check32("mis_still_fault", 32'(fsm_state), 32'(FAULT));
        check1("mis_still_pc_en", pc_en, 1'b0);
        next_cycle(); flush = 1'b1;
        sample();
        check1("mis_flush_pc_en", pc_en, 1'b1);

        // ---- PC+4 wraparound ----
        next_cycle(); flush = 1'b0; pc = 32'hFFFF_FFFC;
        sample();
        check32("wrap_state_idle", 32'(fsm_state), 32'(IDLE));
        check1("wrap_pc_en", pc_en, 1'b1);
        next_cycle(); pc = 32'd0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0BAD_F00D;
        sample();
        next_cycle(); imem_resp_valid = 1'b0;
        sample();
        check32("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        check32("wrap_pc_plus4", id_pc_plus4, 32'd0);

        // ---- reset during WAIT, then a stray response ----
        next_cycle(); id_ready = 1'b1;
        sample();
        check1("rstw_handshake", pc_en, 1'b1);
        next_cycle(); id_ready = 1'b0; rst_n = 1'b0; pc = 32'd4;
        sample();
        check1("rstw_req_valid", imem_req_valid, 1'b0);
        check1("rstw_pc_en", pc_en, 1'b0);
        next_cycle(); rst_n = 1'b1; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
        sample();
        check32("rstw_state", 32'(fsm_state), 32'(IDLE));
        check1("rstw_id_valid", id_valid, 1'b0);
        check32("rstw_instr", id_instr, NOP_INSTR);
        check32("rstw_id_pc", id_pc, 32'd0);
        next_cycle(); imem_resp_valid = 1'b0;
        sample();
        check1("stray_ignored", id_valid, 1'b0);
        check32("stray_instr", id_instr, NOP_INSTR);

        // ---- randomized run ----
        next_cycle(); rst_n = 1'b0; flush = 1'b0; id_ready = 1'b0; imem_req_ready = 1'b0;
        next_cycle(); rst_n = 1'b1; pc = 32'd0;
        model_pc = 32'd0; pend = 1'b0; drop = 1'b0; rem = 0; delivered = 0;
        pend_addr = 32'd0;
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            next_cycle();
            imem_resp_valid = 1'b0;
            resp_live = 1'b0;
            if (pend) begin
                if (rem == 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(pend_addr);
                    resp_live       = !drop;
                    pend            = 1'b0;
                    drop            = 1'b0;
                end else begin
                    rem--;
                end
            end
            flush          = ($urandom_range(0, 24) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            pc             = model_pc;
            sample();

            check1("rnd_pc_en", pc_en, flush | (imem_req_valid & imem_req_ready));
            if (flush) check1("rnd_no_req_on_flush", imem_req_valid, 1'b0);
            if (pend || imem_resp_valid) check1("rnd_one_outstanding", imem_req_valid, 1'b0);
            if (id_valid && !id_ready) check1("rnd_hold_when_full", imem_req_valid, 1'b0);
            if (imem_req_valid) check32("rnd_req_addr", imem_req_addr, model_pc);
            if (resp_live) check1("rnd_slot_empty_on_resp", id_valid, 1'b0);
            if (id_valid) check1("rnd_no_fault", id_misaligned, 1'b0);

            if (id_valid && id_ready && !flush) begin
                check1("rnd_slot_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check32("rnd_id_pc", id_pc, e);
                    check32("rnd_instr", id_instr, mem_word(e));
                    check32("rnd_pc_plus4", id_pc_plus4, e + 32'd4);
                    delivered++;
                end
            end

            if (flush) begin
                exp_q.delete();
                drop = pend;
            end
            hs = imem_req_valid && imem_req_ready && !flush;
            if (hs) begin
                pend      = 1'b1;
                rem       = $urandom_range(1, 4);
                pend_addr = model_pc;
                drop      = 1'b0;
                exp_q.push_back(model_pc);
            end
            if (flush) begin
                model_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
            end else if (hs) begin
                model_pc = model_pc + 32'd4;
            end
        end
        check1("rnd_progress", (delivered >= 100), 1'b1);

        // ---- final report ----
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
